// File: rtl/nh_acc_pkg.sv
// nh_acc_pkg: shared types and constants for the NH coherent accumulator.
//   state_t        : ST_ACC (accumulating epochs) / ST_DUMP (streaming results)
//   DEF_*          : default widths and correlator count
//   DEF_SAT_MAX/MIN: saturation limits for the default accumulator width
package nh_acc_pkg;
    typedef enum logic {ST_ACC = 1'b0, ST_DUMP = 1'b1} state_t;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ACC_W   = 24;
    localparam int DEF_COR_NUM = 8;
    localparam int DEF_IDX_W   = 3;
    localparam int COH_W       = 6;
    localparam logic signed [DEF_ACC_W-1:0] DEF_SAT_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
    localparam logic signed [DEF_ACC_W-1:0] DEF_SAT_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};
endpackage

// File: rtl/nh_acc_sat_add.sv
// nh_acc_sat_add: sign-extending accumulator adder with signed overflow detect.
//   acc   in  ACC_W  current accumulator value
//   val   in  IN_W   signed sample (already sign-stripped)
//   first in  1      first epoch of period: result is val alone (no add)
//   sum   out ACC_W  new accumulator value
//   ovf   out 1      signed overflow occurred on this add
// Macro ACC_SAT_EN: saturate on overflow; otherwise two's-complement wrap.
module nh_acc_sat_add #(
    parameter int IN_W  = 17,
    parameter int ACC_W = 24
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [IN_W-1:0]  val,
    input  logic                    first,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);
`ifdef ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif
    logic signed [ACC_W-1:0] ext, base, raw;
    always_comb begin
        ext  = ACC_W'(val);
        base = first ? '0 : acc;
        raw  = base + ext;
        // overflow: operands share a sign that the result does not
        ovf  = (base[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != base[ACC_W-1]);
`ifdef ACC_SAT_EN
        sum  = ovf ? (base[ACC_W-1] ? SAT_MIN : SAT_MAX) : raw;
`else
        sum  = raw;
`endif
    end
endmodule

// File: rtl/nh_coherent_acc.sv
// nh_coherent_acc: strips the NH secondary-code sign from per-epoch correlator
// results, accumulates coherently over coh_length epochs, then streams the
// COR_NUM accumulated words out over a valid/ready handshake.
//   clk, rst_b (async, active-low), acc_clear (sync soft clear)
//   coh_length   epochs per period (0 treated as 1)
//   nh_code_sel, cur_nh_code1/2   NH bit selection; nh_increase pulses per epoch
//   cor_valid/ready/index/last/i/q   correlator sample input
//   dump_valid/ready/index/last/i/q/ovf   dump output stream
//   coh_count    epochs completed in current period
// Macro ACC_SAT_EN: saturating accumulation (see nh_acc_sat_add).
module nh_coherent_acc
    import nh_acc_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int COR_NUM = DEF_COR_NUM,
    parameter int IDX_W   = DEF_IDX_W
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     acc_clear,
    input  logic [COH_W-1:0]         coh_length,
    input  logic                     nh_code_sel,
    input  logic                     cur_nh_code1,
    input  logic                     cur_nh_code2,
    output logic                     nh_increase,
    input  logic                     cor_valid,
    output logic                     cor_ready,
    input  logic [IDX_W-1:0]         cor_index,
    input  logic                     cor_last,
    input  logic signed [DATA_W-1:0] cor_i,
    input  logic signed [DATA_W-1:0] cor_q,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [IDX_W-1:0]         dump_index,
    output logic                     dump_last,
    output logic signed [ACC_W-1:0]  dump_i,
    output logic signed [ACC_W-1:0]  dump_q,
    output logic                     dump_ovf,
    output logic [COH_W-1:0]         coh_count
);
    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(COR_NUM - 1);

    state_t                  state, state_nx;
    logic signed [ACC_W-1:0] acc_i [COR_NUM];
    logic signed [ACC_W-1:0] acc_q [COR_NUM];
    logic [IDX_W-1:0]        dump_k;
    logic                    ovf_r;
    logic                    accept, epoch_end, period_end, dump_done, sel_bit;
    logic [COH_W:0]          coh_next;
    logic [COH_W-1:0]        coh_eff;
    logic signed [DATA_W:0]  ext_i, ext_q, val_i, val_q;
    logic signed [ACC_W-1:0] sum_i, sum_q;
    logic                    ovf_i, ovf_q;

    always_comb begin
        accept     = cor_valid & cor_ready;
        epoch_end  = accept & cor_last;
        coh_eff    = (coh_length == '0) ? COH_W'(1) : coh_length;
        coh_next   = {1'b0, coh_count} + (COH_W+1)'(1);
        period_end = epoch_end && (coh_next >= {1'b0, coh_eff});
        dump_done  = (state == ST_DUMP) && dump_ready && (dump_k == LAST_K);
        sel_bit    = nh_code_sel ? cur_nh_code2 : cur_nh_code1;
        // one extra bit so that negating -2^(DATA_W-1) stays exact
        ext_i      = {cor_i[DATA_W-1], cor_i};
        ext_q      = {cor_q[DATA_W-1], cor_q};
        val_i      = sel_bit ? -ext_i : ext_i;
        val_q      = sel_bit ? -ext_q : ext_q;
    end

    nh_acc_sat_add #(.IN_W(DATA_W + 1), .ACC_W(ACC_W)) u_add_i (
        .acc   (acc_i[cor_index]),
        .val   (val_i),
        .first (coh_count == '0),
        .sum   (sum_i),
        .ovf   (ovf_i)
    );

    nh_acc_sat_add #(.IN_W(DATA_W + 1), .ACC_W(ACC_W)) u_add_q (
        .acc   (acc_q[cor_index]),
        .val   (val_q),
        .first (coh_count == '0),
        .sum   (sum_q),
        .ovf   (ovf_q)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= ST_ACC;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = acc_clear          ? ST_ACC :
                   (state == ST_ACC)  ? (period_end ? ST_DUMP : ST_ACC) :
                                        (dump_done ? ST_ACC : ST_DUMP);
    end

    always_comb begin
        cor_ready   = (state == ST_ACC);
        dump_valid  = (state == ST_DUMP);
        // the NH generator must not advance on a sample discarded by a clear
        nh_increase = epoch_end & ~acc_clear;
        dump_index  = dump_valid ? dump_k : '0;
        dump_last   = dump_valid && (dump_k == LAST_K);
        dump_i      = dump_valid ? acc_i[dump_k] : '0;
        dump_q      = dump_valid ? acc_q[dump_k] : '0;
        dump_ovf    = ovf_r;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            coh_count <= '0;
            dump_k    <= '0;
            ovf_r     <= 1'b0;
        end else if (acc_clear) begin
            coh_count <= '0;
            dump_k    <= '0;
            ovf_r     <= 1'b0;
        end else begin
            if (epoch_end) coh_count <= period_end ? '0 : coh_next[COH_W-1:0];
            if (state == ST_DUMP && dump_ready) dump_k <= dump_k + IDX_W'(1);
            if (dump_done) ovf_r <= 1'b0;
            else if (accept && (ovf_i || ovf_q)) ovf_r <= 1'b1;
        end
    end

    // contents after a clear are irrelevant: the first epoch overwrites them
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int n = 0; n < COR_NUM; n++) begin
                acc_i[n] <= '0;
                acc_q[n] <= '0;
            end
        end else if (accept && !acc_clear) begin
            acc_i[cor_index] <= sum_i;
            acc_q[cor_index] <= sum_q;
        end
    end
endmodule

// File: tb/tb_nh_coherent_acc.sv
// tb_nh_coherent_acc: directed self-checking bench for nh_coherent_acc (ACC_W=18).
module tb_nh_coherent_acc;
    localparam int DATA_W = 16, ACC_W = 18, COR_NUM = 8, IDX_W = 3;

    logic                     clk = 1'b0;
    logic                     rst_b;
    logic                     acc_clear;
    logic [5:0]               coh_length;
    logic                     nh_code_sel, cur_nh_code1, cur_nh_code2;
    logic                     nh_increase;
    logic                     cor_valid, cor_ready, cor_last;
    logic [IDX_W-1:0]         cor_index;
    logic signed [DATA_W-1:0] cor_i, cor_q;
    logic                     dump_valid, dump_ready, dump_last, dump_ovf;
    logic [IDX_W-1:0]         dump_index;
    logic signed [ACC_W-1:0]  dump_i, dump_q;
    logic [5:0]               coh_count;

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;

    nh_coherent_acc #(.DATA_W(DATA_W), .ACC_W(ACC_W), .COR_NUM(COR_NUM), .IDX_W(IDX_W)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .acc_clear    (acc_clear),
        .coh_length   (coh_length),
        .nh_code_sel  (nh_code_sel),
        .cur_nh_code1 (cur_nh_code1),
        .cur_nh_code2 (cur_nh_code2),
        .nh_increase  (nh_increase),
        .cor_valid    (cor_valid),
        .cor_ready    (cor_ready),
        .cor_index    (cor_index),
        .cor_last     (cor_last),
        .cor_i        (cor_i),
        .cor_q        (cor_q),
        .dump_valid   (dump_valid),
        .dump_ready   (dump_ready),
        .dump_index   (dump_index),
        .dump_last    (dump_last),
        .dump_i       (dump_i),
        .dump_q       (dump_q),
        .dump_ovf     (dump_ovf),
        .coh_count    (coh_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // One epoch of COR_NUM samples, cor_last on the final one; optional clear on the last sample.
    task automatic send_epoch(input logic signed [15:0] si, input logic signed [15:0] sq,
                              input bit n1, input bit n2, input bit clr, input int cc);
        for (int k = 0; k < COR_NUM; k++) begin
            @(negedge clk);
            cor_valid    = 1'b1;
            cor_index    = IDX_W'(k);
            cor_last     = (k == COR_NUM - 1);
            cor_i        = si;
            cor_q        = sq;
            cur_nh_code1 = n1;
            cur_nh_code2 = n2;
            acc_clear    = clr && (k == COR_NUM - 1);
            #1;
            chk("cor_ready", cor_ready, 1);
            chk("nh_increase", nh_increase, (k == COR_NUM - 1) && !clr);
            if (nh_increase) pulses++;
        end
        @(negedge clk);
        cor_valid = 1'b0;
        cor_last  = 1'b0;
        acc_clear = 1'b0;
        chk("coh_count", coh_count, cc);
        chk("dump_valid_after_epoch", dump_valid, (cc == 0) && !clr);
    endtask

    task automatic read_dump(input int ei, input int eq, input bit eo);
        for (int k = 0; k < COR_NUM; k++) begin
            chk("dump_valid", dump_valid, 1);
            chk("dump_index", dump_index, k);
            chk("dump_i", dump_i, ei);
            chk("dump_q", dump_q, eq);
            chk("dump_last", dump_last, k == COR_NUM - 1);
            chk("dump_ovf", dump_ovf, eo);
            chk("cor_ready_dump", cor_ready, 0);
            dump_ready = 1'b1;
            @(negedge clk);
        end
        dump_ready = 1'b0;
        chk("dump_valid_done", dump_valid, 0);
        chk("cor_ready_done", cor_ready, 1);
        chk("dump_ovf_done", dump_ovf, 0);
    endtask

    initial begin
        rst_b = 1'b0; acc_clear = 1'b0; coh_length = 6'd1; nh_code_sel = 1'b0;
        cur_nh_code1 = 1'b0; cur_nh_code2 = 1'b0; cor_valid = 1'b0; cor_index = '0;
        cor_last = 1'b0; cor_i = '0; cor_q = '0; dump_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cor_ready", cor_ready, 1);
        chk("rst_dump_valid", dump_valid, 0);
        chk("rst_dump_i", dump_i, 0);
        chk("rst_coh_count", coh_count, 0);
        chk("rst_nh_increase", nh_increase, 0);
        chk("rst_dump_ovf", dump_ovf, 0);
        rst_b = 1'b1;

        // 1: single-epoch period; code2 set but not selected
        pulses = 0;
        send_epoch(100, -50, 0, 1, 0, 0);
        chk("t1_pulses", pulses, 1);
        read_dump(100, -50, 0);

        // 2: four epochs, NH bits 1,0,1,1 -> -10+10-10-10, -3+3-3-3
        coh_length = 6'd4;
        pulses = 0;
        send_epoch(10, 3, 1, 0, 0, 1);
        send_epoch(10, 3, 0, 1, 0, 2);
        send_epoch(10, 3, 1, 0, 0, 3);
        send_epoch(10, 3, 1, 0, 0, 0);
        chk("t2_pulses", pulses, 4);
        read_dump(-20, -6, 0);

        // 2b: coh_length 0 acts as 1; code2 selected; most-negative input negates exactly
        coh_length = 6'd0;
        nh_code_sel = 1'b1;
        send_epoch(-32768, 7, 0, 1, 0, 0);
        read_dump(32768, -7, 0);
        nh_code_sel = 1'b0;

        // 3: dump back-pressure holds word 0 and blocks upstream
        coh_length = 6'd1;
        send_epoch(1, 2, 0, 0, 0, 0);
        cor_valid = 1'b1; cor_last = 1'b1; cor_index = '0; cor_i = 999; cor_q = 999;
        repeat (5) begin
            #1;
            chk("t3_dump_valid", dump_valid, 1);
            chk("t3_dump_index", dump_index, 0);
            chk("t3_dump_i", dump_i, 1);
            chk("t3_cor_ready", cor_ready, 0);
            chk("t3_nh_increase", nh_increase, 0);
            @(negedge clk);
        end
        cor_valid = 1'b0; cor_last = 1'b0;
        chk("t3_coh_count", coh_count, 0);
        read_dump(1, 2, 0);

        // 4: overflow over 20 epochs of 32767 into 18-bit accumulators
        coh_length = 6'd20;
        for (int e = 0; e < 20; e++) send_epoch(32767, 0, 0, 0, 0, (e + 1) % 20);
`ifdef ACC_SAT_EN
        read_dump(131071, 0, 1);
`else
        read_dump(131052, 0, 1);
`endif
        coh_length = 6'd1;
        send_epoch(1, 1, 0, 0, 0, 0);
        read_dump(1, 1, 0);

        // 5: clear on the second epoch's last sample, then a clean 4-epoch period
        coh_length = 6'd4;
        pulses = 0;
        send_epoch(7, 7, 0, 0, 0, 1);
        send_epoch(7, 7, 0, 0, 1, 0);
        chk("t5_pulses", pulses, 1);
        send_epoch(5, -5, 0, 0, 0, 1);
        send_epoch(5, -5, 0, 0, 0, 2);
        send_epoch(5, -5, 0, 0, 0, 3);
        send_epoch(5, -5, 0, 0, 0, 0);
        read_dump(20, -20, 0);

        // 6: asynchronous reset in the middle of a dump
        coh_length = 6'd1;
        send_epoch(3, 3, 0, 0, 0, 0);
        dump_ready = 1'b1;
        @(negedge clk);
        chk("t6_dump_index_pre", dump_index, 1);
        rst_b = 1'b0;
        #1;
        chk("t6_dump_valid", dump_valid, 0);
        chk("t6_dump_index", dump_index, 0);
        chk("t6_dump_i", dump_i, 0);
        chk("t6_dump_q", dump_q, 0);
        chk("t6_dump_last", dump_last, 0);
        chk("t6_dump_ovf", dump_ovf, 0);
        chk("t6_coh_count", coh_count, 0);
        chk("t6_cor_ready", cor_ready, 1);
        chk("t6_nh_increase", nh_increase, 0);
        dump_ready = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        chk("t6_cor_ready_rel", cor_ready, 1);
        chk("t6_dump_valid_rel", dump_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
